e_muldiv: RTL
=============

# e_muldiv

Execute-stage multiply/divide unit with architectural HI/LO registers for the P7 MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and models fixed multi-cycle latency with a busy flag that the hazard unit uses to stall. It supplies the MFHI/MFLO read value that travels on E_HILO into the E/M pipeline register. An operation issued in the same cycle as an exception request is squashed.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt request; squashes the operation issued this cycle
- start  in  1  valid E-stage mul/div-class instruction this cycle
- op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- busy  out  1  multi-cycle operation in flight
- rdata  out  32  HI when op==MFHI, LO otherwise (combinational)
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Reset: hi=0, lo=0, busy=0, counter=0, pending result=0.
- Accept condition: start & ~req & ~busy. If busy=1, start is ignored; the hazard unit guarantees it never issues one.
- MTHI/MTLO: on an accepted start, hi (or lo) <= a at the next edge. busy stays 0.
- MULT: {HI,LO} = signed 64-bit a*b.
- MULTU: {HI,LO} = unsigned 64-bit a*b.
- DIV: signed division, quotient truncated toward zero to LO; remainder to HI, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (b==0, DIV or DIVU): busy sequence runs normally; hi/lo are left unchanged at completion.
- Result is computed from a/b at accept and held in pending registers. hi/lo are written only at completion, never earlier.
- MFHI/MFLO: no state change, no busy. rdata reflects current hi/lo.
- req while busy: the in-flight operation belongs to an older, committed instruction and completes normally.
- reset while busy: the operation is aborted and all state is cleared.

## Timing
- Accepted start at edge t:
  - busy=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
  - hi/lo are updated at the edge ending cycle t+N.
  - busy=0 and new hi/lo are visible from cycle t+N+1.
- Counter loads N at accept and decrements each cycle while busy. busy = (counter != 0).
- MTHI/MTLO: new value is visible the cycle after accept.
- rdata has zero latency from hi/lo and op.
- The hazard unit stalls any mul/div-class instruction in D while (start & op is a multi-cycle op) | busy.

## Structure
- Shared package `md_pkg`: op encodings (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MFHI=6, MD_MFLO=7) and default cycle constants. The decoder also uses these encodings.
- Single module, no sub-module. Behavioural `*`, `/` and `%` with explicit signed casts; a 64-bit pending register plus a 4-bit counter (sized for DIV_CYCLES).

## Test plan
- MULT a=3, b=0xFFFFFFFE:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU a=7, b=2:
  - busy=1 for 10 cycles.
  - Then lo=3, hi=1.
- DIV a=0xFFFFFFF9 (-7), b=2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF:
  - lo=0x80000000, hi=0.
- DIV with b=0:
  - busy runs 10 cycles.
  - Preloaded hi=0x11, lo=0x22 remain unchanged.
- start=1 (MULT) with req=1 in the same cycle:
  - busy stays 0 and hi/lo are unchanged.
- Second start during busy is ignored; original result is still correct.
- MTLO a=0x1234 then MFLO the next cycle:
  - rdata=0x1234.
- reset asserted in the 3rd busy cycle of a DIV:
  - busy=0, hi=lo=0 the next cycle.
  - No later write occurs.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : md_pkg
//  Description : Shared definitions for the execute-stage multiply/divide
//                unit: operation encodings (also used by the decoder) and
//                default multi-cycle latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Operation encodings carried on the 3-bit op field.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    // Default busy-cycle counts.
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic md_is_multi(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/e_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : e_muldiv
//  Description : E-stage multiply/divide unit with architectural HI/LO.
//                The result is computed at accept and parked in a pending
//                register; HI/LO are committed only when the busy counter
//                runs out, which models a fixed multi-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module e_muldiv
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;      // {HI, LO} waiting for completion
    logic             pend_wr_q, pend_wr_d; // cleared for divide-by-zero
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             div_zero;
    logic             div_ovf;
    logic [31:0]      divisor;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      quo_s, rem_s;
    logic [31:0]      quo_u, rem_u;

    assign busy   = (cnt_q != '0);
    assign accept = start & ~req & ~busy;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign rdata  = (op == MD_MFHI) ? hi_q : lo_q;

    // Arithmetic datapath; the divisor is forced to 1 on zero so the
    // dividers never see a zero operand (the result is discarded anyway).
    always_comb begin
        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        divisor  = div_zero ? 32'd1 : b;
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        quo_u    = a / divisor;
        rem_u    = a % divisor;
        if (div_ovf) begin
            // Most-negative / -1 wraps back to itself with no remainder.
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end else begin
            quo_s = $signed(a) / $signed(divisor);
            rem_s = $signed(a) % $signed(divisor);
        end
    end

    // Next-state: accept a new operation, or count down and commit at the end.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;
        if (accept) begin
            unique case (md_op_e'(op))
                MD_MULT: begin
                    pend_d    = prod_s;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    pend_d    = prod_u;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MD_DIV: begin
                    pend_d    = {rem_s, quo_s};
                    pend_wr_d = ~div_zero;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MD_DIVU: begin
                    pend_d    = {rem_u, quo_u};
                    pend_wr_d = ~div_zero;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = a;
                MD_MTLO: lo_d = a;
                MD_MFHI, MD_MFLO: ;
                default: ;
            endcase
        end else if (busy) begin
            cnt_d = cnt_q - 1'b1;
            if ((cnt_q == CNT_W'(1)) && pend_wr_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule : e_muldiv
`default_nettype wire
